hs32_fetch: RTL and testbench

- Instruction fetch stage for the hs32 core; produces the instruction word that decode stage 1 consumes.
- Issues word reads to the instruction memory port with a valid/grant request and a separate response channel.
- Buffers returned words with their PCs in a small FIFO and presents the head to decode with a valid, held by decode/pipeline stall.
- Handles branch/exception redirects: clears the buffer and discards responses still in flight.

---
 rtl/hs32_fetch.sv | 123 ++++++++++++
 tb/tb_hs32_fetch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hs32_fetch.sv
// rtl/hs32_fetch.sv - hs32 instruction fetch stage with credit-limited request issue and flush/discard handling
//
// Purpose: issues word reads to the instruction memory, buffers returned words
// together with their PCs in a DEPTH-entry FIFO and presents the head to decode.
// A redirect (flush) clears the buffer and drops every response still in flight.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   req_o, addr_o        memory read request valid / word address
//   gnt_i                memory accepts the request this cycle
//   rvalid_i, rdata_i    in-order read response
//   vld_o, instr_o, pc_o FIFO head presented to decode
//   stall_i              downstream stall, holds the head
//   flush_i, flush_pc_i  redirect request and target
module hs32_fetch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        vld_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [CW:0]   credits;
  logic [31:0]   flush_tgt;
  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign credits   = {1'b0, count} + {1'b0, outstanding};
  assign flush_tgt = {flush_pc_i[31:2], 2'b00};

  assign req_o  = rstn_i && !flush_i && (credits < (CW+1)'(DEPTH));
  assign addr_o = fpc;
  assign grant  = req_o && gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp = rvalid_i && (outstanding != '0);
  // Responses are dropped while draining pre-flush requests or during a flush.
  assign push = resp && (discard == '0) && !flush_i;
  assign pop  = vld_o && !stall_i && !flush_i;

  assign vld_o   = (count != '0);
  assign instr_o = vld_o ? data_mem[rd_ptr] : 32'h0;
  assign pc_o    = vld_o ? pc_mem[rd_ptr]   : 32'h0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fpc         <= RESET_VEC;
      rpc         <= RESET_VEC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      // req_o is low during a flush, so grant cannot coincide with it.
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (flush_i) begin
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        fpc     <= flush_tgt;
        rpc     <= flush_tgt;
        // Everything still in flight after this cycle belongs to the old stream.
        discard <= outstanding - CW'(resp);
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (grant) begin
          fpc <= fpc + 32'd4;
        end
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          rpc    <= rpc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (resp && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rpc;
      data_mem[wr_ptr] <= rdata_i;
    end
  end

endmodule

// File: tb/tb_hs32_fetch.sv
// tb/tb_hs32_fetch.sv - randomized self-checking bench for hs32_fetch against an epoch-based stream model
module tb_hs32_fetch;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        vld_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  hs32_fetch #(.DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_o      (req_o),
    .addr_o     (addr_o),
    .gnt_i      (gnt_i),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i),
    .vld_o      (vld_o),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .flush_pc_i (flush_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // Each granted request remembers the fetch epoch it belongs to; a flush
  // starts a new epoch, and responses from older epochs never reach decode.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] epoch;
  } ent_t;

  ent_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fpc_m;
  logic [31:0] epoch;

  int vectors     = 0;
  int miscompares = 0;
  int p_gnt, p_rv, p_stall, p_flush;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    mem_q.delete();
    exp_q.delete();
    fpc_m = RESET_VEC;
    epoch = 0;
  endtask

  task automatic apply_reset(input int cycles);
    rstn_i     = 1'b0;
    gnt_i      = 1'b0;
    rvalid_i   = 1'b0;
    rdata_i    = 32'h0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    flush_pc_i = 32'h0;
    reset_model();
    for (int i = 0; i < cycles; i++) begin
      #1;
      check_val("rst_req",   {31'b0, req_o}, 32'h0);
      check_val("rst_vld",   {31'b0, vld_o}, 32'h0);
      check_val("rst_instr", instr_o, 32'h0);
      check_val("rst_pc",    pc_o,    32'h0);
      @(negedge clk_i);
    end
    rstn_i = 1'b1;
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_1003;
      1:       return 32'hFFFF_FFF0 | {30'b0, r[1:0]};
      default: return r;
    endcase
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, advance the model.
  task automatic step();
    logic        exp_req;
    logic        grant_m;
    logic        do_pop;
    ent_t        e;

    flush_i    = ($urandom_range(0, 99) < p_flush);
    flush_pc_i = pick_target();
    stall_i    = ($urandom_range(0, 99) < p_stall);
    gnt_i      = ($urandom_range(0, 99) < p_gnt);
    rvalid_i   = 1'b0;
    rdata_i    = $urandom;
    if (mem_q.size() != 0) begin
      if ($urandom_range(0, 99) < p_rv) begin
        rvalid_i = 1'b1;
        rdata_i  = mem_word(mem_q[0].addr);
      end
    end else if ($urandom_range(0, 99) < 5) begin
      rvalid_i = 1'b1;  // stray response with nothing outstanding
    end
    #1;

    exp_req = !flush_i && ((exp_q.size() + mem_q.size()) < DEPTH);
    check_val("vld", {31'b0, vld_o}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_val("pc",    pc_o,    exp_q[0]);
      check_val("instr", instr_o, mem_word(exp_q[0]));
    end
    check_val("req", {31'b0, req_o}, {31'b0, exp_req});
    if (exp_req) begin
      check_val("addr", addr_o, fpc_m);
    end

    grant_m = exp_req && gnt_i;
    do_pop  = (exp_q.size() != 0) && !stall_i && !flush_i;
    if (do_pop) begin
      void'(exp_q.pop_front());
    end
    if (rvalid_i && mem_q.size() != 0) begin
      e = mem_q.pop_front();
      if (!flush_i && e.epoch == epoch) begin
        exp_q.push_back(e.addr);
      end
    end
    if (flush_i) begin
      epoch++;
      exp_q.delete();
      fpc_m = {flush_pc_i[31:2], 2'b00};
    end else if (grant_m) begin
      mem_q.push_back('{addr: fpc_m, epoch: epoch});
      fpc_m = fpc_m + 32'd4;
    end
    @(negedge clk_i);
  endtask

  int ph_gnt   [8] = '{100, 100,  30, 100,  60,  80,  50,  90};
  int ph_rv    [8] = '{100, 100,  30,  40,  70,  60,  90,  20};
  int ph_stall [8] = '{  0, 100,  10,  40,  30,  60,  20,  50};
  int ph_flush [8] = '{  0,   0,   3,  20,   5,  10,  40,   8};

  initial begin
    rstn_i = 1'b0;
    apply_reset(3);
    for (int ph = 0; ph < 8; ph++) begin
      p_gnt   = ph_gnt[ph];
      p_rv    = ph_rv[ph];
      p_stall = ph_stall[ph];
      p_flush = ph_flush[ph];
      if (ph == 5) begin
        apply_reset(2);
      end
      for (int c = 0; c < 300; c++) begin
        step();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
